aes_key_mem: RTL and testbench
==============================

AES_KEY_MEM -- requirements
Module: aes_key_mem

Interface
REQ-001 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-002 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port init  input  1  start key expansion; sampled on rising clk.
REQ-004 SHALL have port key  input  128  AES-128 cipher key, big-endian, w0 = key[127:96].
REQ-005 SHALL have port round  input  4  round-key index 0..10 requested by the cipher core.
REQ-006 SHALL have port round_key  output  128  stored round key for index round.
REQ-007 SHALL have port ready  output  1  high when all 11 round keys are valid and the block is idle.
REQ-008 SHALL have port sboxw  output  32  word sent to the shared external S-box.
REQ-009 SHALL have port new_sboxw  input  32  substituted word returned combinationally, same cycle.

Function
REQ-010 SHALL implement FSM states IDLE, GEN, with IDLE as the reset state.
REQ-011 In IDLE, init=1 at edge E0 SHALL:
  - write key into mem[0] and the working register;
  - clear the round counter to 1;
  - drop ready;
  - enter GEN.
REQ-012 In GEN, each edge SHALL write mem[ctr] = next_key(working, Rcon[ctr]), update working, and increment ctr.
REQ-013 next_key SHALL follow FIPS-197:
  - t = new_sboxw ^ {Rcon,24'h0};
  - w4 = w0^t, w5 = w4^w1, w6 = w5^w2, w7 = w6^w3.
REQ-014 sboxw SHALL be RotWord(working[31:0]) = {w3[23:0], w3[31:24]}, combinational, in every state.
REQ-015 Rcon for rounds 1..10 SHALL be 01,02,04,08,10,20,40,80,1B,36 (hex).
REQ-016 After the edge writing mem[10] (edge E10), the FSM SHALL enter IDLE and set ready=1; latency from init to ready is exactly 10 cycles.
REQ-017 round_key SHALL be a combinational read of mem[round]; round values 11..15 SHALL return all-zero.
REQ-018 init asserted during GEN SHALL restart expansion from the new key, with the same rule as REQ-011.
REQ-019 While ready=0, round_key contents for indices not yet written are undefined to the consumer; the cipher core SHALL NOT start until ready=1.
REQ-020 key need be stable only at the init edge; later key changes SHALL NOT affect the stored keys.

Reset
REQ-021 reset=0 SHALL immediately force:
  - FSM to IDLE;
  - ctr=0;
  - working register and all mem entries to 0;
  - ready=1.
REQ-022 Reset asserted mid-GEN SHALL abort expansion with no partial keys retained.

Configuration
REQ-023 Macro AES_KEY_ZEROIZE_EN, when defined, SHALL add port zeroize (input, 1 bit).
REQ-024 With AES_KEY_ZEROIZE_EN, zeroize=1 on an edge SHALL:
  - clear all mem entries and the working register;
  - force IDLE;
  - set ready=0 until the next completed expansion.
REQ-025 zeroize SHALL take priority over a simultaneous init.
REQ-026 Without AES_KEY_ZEROIZE_EN, the port and logic SHALL be absent, and behaviour SHALL be exactly REQ-010..022.

Structure
REQ-027 Package aes_pkg SHALL hold:
  - the Rcon table;
  - FSM state encodings;
  - AES_NR=10;
  - the 128-bit block width constant.
REQ-028 The combinational one-round key function SHALL be a sub-module aes_key_round, with inputs prev_key, new_sboxw and rcon, and output next_key.
REQ-029 The S-box SHALL stay external, shared with aes_encipher through the sboxw/new_sboxw pair.

Verification
REQ-030 Reset, then idle: ready=1, round_key=0 for all round values, sboxw=0.
REQ-031 Key 000102030405060708090a0b0c0d0e0f, init one cycle; expected results:
  - ready rises 10 cycles later;
  - round 1 = d6aa74fdd2af72fadaa678f1d6ab76fe;
  - round 10 = 13111d7fe3944a17f307a78b4d2b30c5.
REQ-032 Key 2b7e151628aed2a6abf7158809cf4f3c; expected results:
  - round 0 = key;
  - round 1 = a0fafe1788542cb123a339392a6c7605;
  - round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
REQ-033 Re-init with the second key at GEN cycle 5 of the first key: after 10 cycles from the re-init, round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
REQ-034 reset pulsed at GEN cycle 3: ready=1 and all mem entries = 0 immediately; a later init completes normally.
REQ-035 With AES_KEY_ZEROIZE_EN, zeroize after a completed expansion: all rounds read 0 and ready=0; zeroize together with init leaves the FSM in IDLE.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES-128 key-schedule constants: Rcon table, FSM encoding, round count and block width.
package aes_pkg;

  localparam int AES_NR      = 10;
  localparam int AES_BLOCK_W = 128;

  typedef enum logic {
    IDLE = 1'b0,
    GEN  = 1'b1
  } key_state_t;

  // Rcon indexed by round number 1..10; other indices are never used in GEN.
  function automatic logic [7:0] get_rcon(input logic [3:0] rnd);
    logic [7:0] rc;
    case (rnd)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

endpackage

// File: rtl/aes_key_round.sv
// One AES-128 key-schedule step; the SubWord result arrives from the shared external S-box.
module aes_key_round
  import aes_pkg::*;
(
  input  logic [AES_BLOCK_W-1:0] prev_key,
  input  logic [31:0]            new_sboxw,
  input  logic [7:0]             rcon,
  output logic [AES_BLOCK_W-1:0] next_key
);

  logic [31:0] t_w;
  logic [31:0] w4, w5, w6, w7;

  assign t_w = new_sboxw ^ {rcon, 24'h0};
  assign w4  = prev_key[127:96] ^ t_w;
  assign w5  = w4 ^ prev_key[95:64];
  assign w6  = w5 ^ prev_key[63:32];
  assign w7  = w6 ^ prev_key[31:0];

  assign next_key = {w4, w5, w6, w7};

endmodule

// File: rtl/aes_key_mem.sv
// AES-128 round-key memory: expands a cipher key into 11 stored round keys, one per cycle.
// Optional AES_KEY_ZEROIZE_EN adds a zeroize input that wipes all key material.
module aes_key_mem
  import aes_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   init,
`ifdef AES_KEY_ZEROIZE_EN
  input  logic                   zeroize,
`endif
  input  logic [AES_BLOCK_W-1:0] key,
  input  logic [3:0]             round,
  output logic [AES_BLOCK_W-1:0] round_key,
  output logic                   ready,
  output logic [31:0]            sboxw,
  input  logic [31:0]            new_sboxw
);

  key_state_t             state_q, state_d;
  logic [3:0]             ctr_q, ctr_d;
  logic                   ready_q, ready_d;
  logic [AES_BLOCK_W-1:0] work_q, work_d;
  logic [AES_BLOCK_W-1:0] mem_q [0:AES_NR];
  logic [AES_BLOCK_W-1:0] mem_d [0:AES_NR];
  logic [AES_BLOCK_W-1:0] next_key;

  aes_key_round u_round (
    .prev_key  (work_q),
    .new_sboxw (new_sboxw),
    .rcon      (get_rcon(ctr_q)),
    .next_key  (next_key)
  );

  assign sboxw     = {work_q[23:0], work_q[31:24]};
  assign ready     = ready_q;
  assign round_key = (round <= 4'(AES_NR)) ? mem_q[round] : '0;

  always_comb begin
    state_d = state_q;
    ctr_d   = ctr_q;
    ready_d = ready_q;
    work_d  = work_q;
    mem_d   = mem_q;
    // init restarts expansion from any state, including mid-GEN.
    if (init) begin
      mem_d[0] = key;
      work_d   = key;
      ctr_d    = 4'd1;
      ready_d  = 1'b0;
      state_d  = GEN;
    end else if (state_q == GEN) begin
      mem_d[ctr_q] = next_key;
      work_d       = next_key;
      ctr_d        = ctr_q + 4'd1;
      if (ctr_q == 4'(AES_NR)) begin
        state_d = IDLE;
        ready_d = 1'b1;
      end
    end
`ifdef AES_KEY_ZEROIZE_EN
    // Zeroize overrides everything above, including a simultaneous init.
    if (zeroize) begin
      for (int i = 0; i <= AES_NR; i++) mem_d[i] = '0;
      work_d  = '0;
      ctr_d   = 4'd0;
      ready_d = 1'b0;
      state_d = IDLE;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      ctr_q   <= 4'd0;
      ready_q <= 1'b1;
      work_q  <= '0;
      for (int i = 0; i <= AES_NR; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      ctr_q   <= ctr_d;
      ready_q <= ready_d;
      work_q  <= work_d;
      for (int i = 0; i <= AES_NR; i++) mem_q[i] <= mem_d[i];
    end
  end

endmodule

// File: tb/tb_aes_key_mem.sv
// Self-checking bench for aes_key_mem: provides the external S-box and a key-schedule scoreboard.
module tb_aes_key_mem;

  logic         clk = 1'b0;
  logic         reset;
  logic         init;
  logic [127:0] key;
  logic [3:0]   round;
  logic [127:0] round_key;
  logic         ready;
  logic [31:0]  sboxw;
  logic [31:0]  new_sboxw;
`ifdef AES_KEY_ZEROIZE_EN
  logic         zeroize;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]   sbox_tab [0:255];
  logic [7:0]   rcon_tb  [1:10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                    8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
  logic [127:0] sb_q [$];

  localparam logic [127:0] KEY_A   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] KEY_A1  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
  localparam logic [127:0] KEY_A10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] KEY_B   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KEY_B1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] KEY_B10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  always #5 clk = ~clk;

  aes_key_mem dut (
    .clk       (clk),
    .reset     (reset),
    .init      (init),
`ifdef AES_KEY_ZEROIZE_EN
    .zeroize   (zeroize),
`endif
    .key       (key),
    .round     (round),
    .round_key (round_key),
    .ready     (ready),
    .sboxw     (sboxw),
    .new_sboxw (new_sboxw)
  );

  always_comb new_sboxw = {sbox_tab[sboxw[31:24]], sbox_tab[sboxw[23:16]],
                           sbox_tab[sboxw[15:8]],  sbox_tab[sboxw[7:0]]};

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++)
        if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      sbox_tab[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  // Reference FIPS-197 expansion; pushes all 11 expected round keys.
  task automatic push_expected(input logic [127:0] k);
    logic [127:0] w;
    logic [31:0]  t, r, w4, w5, w6, w7;
    w = k;
    sb_q.push_back(w);
    for (int rn = 1; rn <= 10; rn++) begin
      r  = {w[23:0], w[31:24]};
      t  = {sbox_tab[r[31:24]], sbox_tab[r[23:16]], sbox_tab[r[15:8]], sbox_tab[r[7:0]]}
           ^ {rcon_tb[rn], 24'h0};
      w4 = w[127:96] ^ t;
      w5 = w4 ^ w[95:64];
      w6 = w5 ^ w[63:32];
      w7 = w6 ^ w[31:0];
      w  = {w4, w5, w6, w7};
      sb_q.push_back(w);
    end
  endtask

  // Pulses init for one edge (E0), then scrambles key to prove it is not re-sampled.
  task automatic start_init(input logic [127:0] k);
    @(negedge clk);
    key  = k;
    init = 1'b1;
    push_expected(k);
    @(posedge clk);
    @(negedge clk);
    init = 1'b0;
    key  = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic wait_ready(input string name);
    int cyc;
    cyc = 0;
    while (!ready && cyc < 20) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    n_checks++;
    if (cyc != 10) begin
      n_fail++;
      $display("FAIL %s latency: got %0d cycles (ready=%b), expected 10", name, cyc, ready);
    end
  endtask

  task automatic check_rounds(input string name, input logic [127:0] exp1,
                              input logic [127:0] exp10);
    logic [127:0] exp;
    for (int r = 0; r <= 10; r++) begin
      exp   = (sb_q.size() != 0) ? sb_q.pop_front() : 128'hx;
      round = 4'(r);
      #1;
      n_checks++;
      if (round_key !== exp) begin
        n_fail++;
        $display("FAIL %s round%0d: got %h expected %h", name, r, round_key, exp);
      end
      if (r == 1 || r == 10) begin
        n_checks++;
        if (round_key !== ((r == 1) ? exp1 : exp10)) begin
          n_fail++;
          $display("FAIL %s vector round%0d: got %h expected %h", name, r, round_key,
                   (r == 1) ? exp1 : exp10);
        end
      end
    end
    for (int r = 11; r <= 15; r++) begin
      round = 4'(r);
      #1;
      n_checks++;
      if (round_key !== 128'h0) begin
        n_fail++;
        $display("FAIL %s round%0d out-of-range: got %h expected 0", name, r, round_key);
      end
    end
    $display("%s: expansion checked, round10=%h", name, exp10);
  endtask

  task automatic check_all_zero(input string name);
    for (int r = 0; r <= 15; r++) begin
      round = 4'(r);
      #1;
      n_checks++;
      if (round_key !== 128'h0) begin
        n_fail++;
        $display("FAIL %s round%0d: got %h expected 0", name, r, round_key);
      end
    end
    n_checks++;
    if (sboxw !== 32'h0) begin
      n_fail++;
      $display("FAIL %s sboxw: got %h expected 0", name, sboxw);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset ready: got %b expected 1", ready);
    end
    check_all_zero("reset");
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (ready !== 1'b1) begin
      n_fail++;
      $display("FAIL idle ready: got %b expected 1", ready);
    end
    check_all_zero("idle");
    $display("reset/idle: checked");
  endtask

  task automatic test_expand(input string name, input logic [127:0] k,
                             input logic [127:0] exp1, input logic [127:0] exp10);
    start_init(k);
    n_checks++;
    if (ready !== 1'b0) begin
      n_fail++;
      $display("FAIL %s ready after init: got %b expected 0", name, ready);
    end
    wait_ready(name);
    check_rounds(name, exp1, exp10);
  endtask

  task automatic test_reinit();
    start_init(KEY_A);
    repeat (4) begin
      @(posedge clk);
      @(negedge clk);
    end
    sb_q.delete();
    start_init(KEY_B);
    wait_ready("reinit");
    check_rounds("reinit", KEY_B1, KEY_B10);
  endtask

  task automatic test_reset_mid();
    start_init(KEY_B);
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
    end
    reset = 1'b0;
    #1;
    n_checks++;
    if (ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid ready: got %b expected 1", ready);
    end
    check_all_zero("reset_mid");
    sb_q.delete();
    @(negedge clk);
    reset = 1'b1;
    $display("reset_mid: abort checked");
    test_expand("after_reset", KEY_A, KEY_A1, KEY_A10);
  endtask

`ifdef AES_KEY_ZEROIZE_EN
  task automatic test_zeroize();
    @(negedge clk);
    zeroize = 1'b1;
    @(negedge clk);
    zeroize = 1'b0;
    n_checks++;
    if (ready !== 1'b0) begin
      n_fail++;
      $display("FAIL zeroize ready: got %b expected 0", ready);
    end
    check_all_zero("zeroize");
    key     = KEY_B;
    init    = 1'b1;
    zeroize = 1'b1;
    @(negedge clk);
    init    = 1'b0;
    zeroize = 1'b0;
    repeat (12) @(negedge clk);
    n_checks++;
    if (ready !== 1'b0) begin
      n_fail++;
      $display("FAIL zeroize_init ready: got %b expected 0", ready);
    end
    check_all_zero("zeroize_init");
    $display("zeroize: checked");
    test_expand("after_zeroize", KEY_B, KEY_B1, KEY_B10);
  endtask
`endif

  initial begin
    reset = 1'b0;
    init  = 1'b0;
    key   = '0;
    round = 4'd0;
`ifdef AES_KEY_ZEROIZE_EN
    zeroize = 1'b0;
`endif
    build_sbox();
    test_reset();
    test_expand("key_a", KEY_A, KEY_A1, KEY_A10);
    test_expand("key_b", KEY_B, KEY_B1, KEY_B10);
    test_reinit();
    test_reset_mid();
`ifdef AES_KEY_ZEROIZE_EN
    test_zeroize();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
